// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst master: one command = one burst of cmd_len beats,
// with a streaming write-data input, a read-data output and an ack timeout.
module wb_burst_master #(
  parameter int dw   = 32,
  parameter int aw   = 26,
  parameter int bl   = 5,
  parameter int to_w = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [aw-1:0]   cmd_addr,
  input  logic [bl-1:0]   cmd_len,
  input  logic [dw-1:0]   wdata,
  input  logic            wdata_valid,
  output logic            wdata_ready,
  output logic [dw-1:0]   rdata,
  output logic            rdata_valid,
  output logic            done,
  output logic            err,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [aw-1:0]   wb_addr_o,
  output logic [dw-1:0]   wb_dat_o,
  output logic [dw/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic            wb_ack_i
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DONE} state_t;

  localparam int unsigned to_last = (1 << to_w) - 2;

  state_t          state, state_n;
  logic [aw-1:0]   addr_q;
  logic [bl-1:0]   rem_q;
  logic [to_w-1:0] to_cnt;
  logic            err_q;
  logic            accept, ack_ok, last_beat, counting, to_hit;

  always_comb begin
    cmd_ready   = (state == S_IDLE) && !wb_rst_i;
    accept      = cmd_valid && cmd_ready;
    wb_cyc_o    = (state == S_WR) || (state == S_RD);
    wb_we_o     = (state == S_WR);
    wb_stb_o    = ((state == S_WR) && wdata_valid) || (state == S_RD);
    wb_addr_o   = addr_q;
    wb_dat_o    = wdata;
    wb_sel_o    = '1;
    ack_ok      = wb_ack_i && wb_stb_o;
    last_beat   = (rem_q == bl'(1));
    wdata_ready = (state == S_WR) && ack_ok;
    // Master wait states in WR freeze the timeout; a same-cycle ack beats the timeout.
    counting    = (state == S_RD) || ((state == S_WR) && wdata_valid);
    to_hit      = counting && !ack_ok && (to_cnt == to_w'(to_last));
    wb_cti_o    = wb_cyc_o ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
    done        = (state == S_DONE);
    err         = (state == S_DONE) && err_q;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd_len == '0) state_n = S_DONE;
          else               state_n = cmd_write ? S_WR : S_RD;
        end
      end
      S_WR, S_RD: begin
        if ((ack_ok && last_beat) || to_hit) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      to_cnt      <= '0;
      err_q       <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      state       <= state_n;
      rdata_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q <= cmd_addr;
            rem_q  <= cmd_len;
            to_cnt <= '0;
            err_q  <= 1'b0;
          end
        end
        S_WR, S_RD: begin
          if (ack_ok) begin
            addr_q <= addr_q + aw'(dw / 8);
            rem_q  <= rem_q - bl'(1);
            to_cnt <= '0;
            if (state == S_RD) begin
              rdata       <= wb_dat_i;
              rdata_valid <= 1'b1;
            end
          end else if (counting) begin
            to_cnt <= to_cnt + to_w'(1);
            if (to_hit) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master against a small Wishbone memory slave.
module tb_wb_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [25:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic [31:0] wdata;
  logic        wdata_valid, wdata_ready;
  logic [31:0] rdata;
  logic        rdata_valid, done, err;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [25:0] wb_addr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        ack_en;

  logic [31:0] mem [1024];
  logic [31:0] wd [8];

  typedef struct {
    logic [25:0] addr;
    logic        we;
    logic [31:0] data;
    logic [2:0]  cti;
  } beat_t;

  beat_t       exp_bus[$];
  logic [31:0] exp_rd[$];
  logic        exp_err[$];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_burst_master #(.dw(32), .aw(26), .bl(5), .to_w(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  // Zero-wait-state slave: acks combinationally whenever enabled and strobed.
  always_comb begin
    wb_ack_i = ack_en && wb_cyc_o && wb_stb_o;
    wb_dat_i = mem[wb_addr_o[11:2]];
  end

  always @(posedge clk)
    if (wb_ack_i && wb_we_o) mem[wb_addr_o[11:2]] <= wb_dat_o;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void flag(string name, logic [31:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %0h expected no event", name, act);
  endfunction

  // Monitor: pops expectations whenever the DUT presents a bus beat, read beat or done.
  always @(negedge clk) begin
    beat_t b;
    logic  e;
    if (wb_ack_i && wb_stb_o) begin
      if (exp_bus.size() == 0) flag("unexpected_beat", 32'(wb_addr_o));
      else begin
        b = exp_bus.pop_front();
        check("beat_addr", 32'(wb_addr_o), 32'(b.addr));
        check("beat_we", 32'(wb_we_o), 32'(b.we));
        check("beat_cti", 32'(wb_cti_o), 32'(b.cti));
        check("beat_sel", 32'(wb_sel_o), 32'hF);
        if (b.we) check("beat_wdata", wb_dat_o, b.data);
      end
    end
    if (rdata_valid) begin
      if (exp_rd.size() == 0) flag("unexpected_rdata", rdata);
      else check("rdata", rdata, exp_rd.pop_front());
    end
    if (done) begin
      if (exp_err.size() == 0) flag("unexpected_done", 32'(err));
      else begin
        e = exp_err.pop_front();
        check("done_err", 32'(err), 32'(e));
      end
    end else if (err) flag("err_without_done", 32'(err));
  end

  task automatic push_beats(input logic [25:0] a, input int len, input logic we, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.addr = a + 26'(4 * i);
      b.we   = we;
      b.data = wd[i];
      b.cti  = (i == len - 1) ? 3'b111 : 3'b010;
      exp_bus.push_back(b);
    end
  endtask

  task automatic send_cmd(input logic we, input logic [25:0] a, input logic [4:0] len);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_write = we;
    cmd_addr  = a;
    cmd_len   = len;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) flag("cmd_accept_timeout", 32'(t));
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic push_wbeat(input int i);
    int t = 0;
    wdata = wd[i];
    wdata_valid = 1'b1;
    @(negedge clk);
    while (!wdata_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!wdata_ready) flag("wdata_ready_timeout", 32'(i));
    @(posedge clk);
    #1 wdata_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [25:0] a, input int len, input int gap_beat, input int gap);
    push_beats(a, len, 1'b1, len);
    exp_err.push_back(1'b0);
    send_cmd(1'b1, a, 5'(len));
    for (int i = 0; i < len; i++) begin
      if (i == gap_beat) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("gap_stb", 32'(wb_stb_o), 32'd0);
          check("gap_cyc", 32'(wb_cyc_o), 32'd1);
          check("gap_addr", 32'(wb_addr_o), 32'(a + 26'(4 * i)));
          @(posedge clk);
          #1;
        end
      end
      push_wbeat(i);
    end
    @(negedge clk);
    check("wr_done_after_last", 32'(done), 32'd1);
    check("ready_low_in_done", 32'(cmd_ready), 32'd0);
    check("cyc_low_in_done", 32'(wb_cyc_o), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic read_burst(input logic [25:0] a, input int len);
    int t = 0;
    push_beats(a, len, 1'b0, len);
    for (int i = 0; i < len; i++) exp_rd.push_back(wd[i]);
    exp_err.push_back(1'b0);
    send_cmd(1'b0, a, 5'(len));
    @(negedge clk);
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rd_done_latency", 32'(t), 32'(len));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    rst = 1'b1; ack_en = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata = '0; wdata_valid = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_cti", 32'(wb_cti_o), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    // 4-beat write then read-back
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
    write_burst(26'h100, 4, -1, 0);
    read_burst(26'h100, 4);

    // 3-beat write with a 5-cycle master wait state before beat 2
    wd[0] = 32'h55555555; wd[1] = 32'h66666666; wd[2] = 32'h77777777;
    write_burst(26'h200, 3, 1, 5);
    read_burst(26'h200, 3);

    // Read with no ack: timeout after 15 cycles with cyc high
    ack_en = 1'b0;
    exp_err.push_back(1'b1);
    send_cmd(1'b0, 26'h100, 5'd2);
    t = 0;
    @(negedge clk);
    while (!done && t < 50) begin
      if (wb_cyc_o) t++;
      @(negedge clk);
    end
    check("timeout_cycles", 32'(t), 32'd15);
    check("timeout_err", 32'(err), 32'd1);
    @(posedge clk);
    #1 ack_en = 1'b1;

    // Reset during beat 3 of an 8-beat write
    for (int i = 0; i < 8; i++) wd[i] = 32'hA0A0A000 + 32'(i);
    push_beats(26'h300, 8, 1'b1, 3);
    send_cmd(1'b1, 26'h300, 5'd8);
    push_wbeat(0);
    push_wbeat(1);
    wdata = wd[2]; wdata_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; wdata_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_mid_stb", 32'(wb_stb_o), 32'd0);
    check("rst_mid_cti", 32'(wb_cti_o), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // New command after reset completes normally
    wd[0] = 32'hDEADBEEF; wd[1] = 32'hCAFEF00D;
    write_burst(26'h3F8, 2, -1, 0);
    read_burst(26'h3F8, 2);

    // Zero-length command: done without any bus cycle
    exp_err.push_back(1'b0);
    send_cmd(1'b1, 26'h40, 5'd0);
    @(negedge clk);
    check("len0_done", 32'(done), 32'd1);
    check("len0_ready", 32'(cmd_ready), 32'd0);
    check("len0_cyc", 32'(wb_cyc_o), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("len0_done_cleared", 32'(done), 32'd0);
    check("len0_ready_back", 32'(cmd_ready), 32'd1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("leftover_beats", 32'(exp_bus.size()), 32'd0);
    check("leftover_rdata", 32'(exp_rd.size()), 32'd0);
    check("leftover_done", 32'(exp_err.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
Synthesizable Wishbone B3 master that drives the system-side Wishbone port of the SDRAM controller top.
- Accepts single-command requests: write/read, start byte address, beat count.
- Runs each request as an incrementing burst (CTI 010, last beat 111).
- Streams write data in and read data out.
- Used by the on-chip memory test engine and as a synthesizable stimulus source in place of the bench driver.

Parameters:
- dw, 32, Wishbone data width in bits (multiple of 8).
- aw, 26, Wishbone byte-address width.
- bl, 5, beat-count field width; max burst = 2^bl-1 beats.
- to_w, 8, ack-timeout counter width; timeout = 2^to_w-1 cycles.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  aw  start byte address, dw/8-aligned.
- cmd_len  in  bl  number of beats.
- wdata  in  dw  write beat data.
- wdata_valid  in  1  write beat available.
- wdata_ready  out  1  write beat consumed this cycle.
- rdata  out  dw  read beat data.
- rdata_valid  out  1  read beat valid (single-cycle pulse; no backpressure).
- done  out  1  one-cycle pulse at command completion.
- err  out  1  one-cycle pulse with done when the command was aborted by timeout.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  write enable.
- wb_addr_o  out  aw  byte address.
- wb_dat_o  out  dw  write data.
- wb_sel_o  out  dw/8  byte selects, always all-ones.
- wb_cti_o  out  3  cycle type.
- wb_dat_i  in  dw  read data.
- wb_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset (synchronous, active-high): on the first rising edge with wb_rst_i=1, state=IDLE and all registered outputs=0. This holds even mid-burst: cyc/stb drop at that edge and no done pulse is emitted. cmd_ready=0 while wb_rst_i=1.
- State machine:
  - IDLE: cmd_ready=1. On accept, latch addr, len, write flag; next state WR or RD. cmd_len=0 goes to DONE directly, with no bus cycle.
  - WR: wb_cyc_o=1, wb_we_o=1. wb_stb_o=wdata_valid (master wait states allowed). wb_dat_o=wdata; wdata_ready=wb_ack_i&wb_stb_o.
  - RD: wb_cyc_o=1, wb_stb_o=1, wb_we_o=0. On ack: rdata<=wb_dat_i and rdata_valid=1 in the next cycle (1-cycle latency).
  - DONE: done=1 for one cycle; cyc/stb=0; next state IDLE. cmd_ready=0 in DONE, so back-to-back commands have at least one idle cycle.
- Per ack in WR/RD:
  - wb_addr_o += dw/8; wrap modulo 2^aw.
  - remaining beats -= 1.
  - On the ack of the last beat: go to DONE, and cyc/stb deassert in the following cycle.
- CTI: 3'b010 while remaining beats > 1; 3'b111 on the final beat, including 1-beat commands. 0 when idle.
- Timeout: counter clears on every ack and on entry to WR/RD. It increments each cycle with cyc=1 and no ack; in WR it holds while wdata_valid=0.
  - On reaching 2^to_w-1: go to DONE with err=1.
  - Remaining beats are discarded; no further wdata_ready or rdata_valid.
- An ack while stb=0 is ignored.
- An ack arriving in the same cycle as the timeout terminal count is counted as a good beat; no err is raised.

Test Plan:
- Write cmd addr=0x100, len=4; data 0x11111111..0x44444444; slave acks every cycle → 4 acks; addrs 0x100,0x104,0x108,0x10C; cti 010,010,010,111; done pulse one cycle after 4th ack; err=0.
- Read cmd addr=0x100, len=4, after the write above through the SDRAM controller + memory model → rdata_valid four times with 0x11111111..0x44444444 in order; done=1.
- Write len=3 with wdata_valid low for 5 cycles before beat 2 → stb low during gap; cyc stays high; no timeout; addresses unchanged across gap.
- Read len=2 with slave never acking, to_w=4 → done and err pulse together 15 cycles after cyc rises; no rdata_valid.
- wb_rst_i asserted for 1 cycle during beat 3 of an 8-beat write → cyc/stb/cti=0 at next edge; no done; new command accepted afterwards and completes normally.
- cmd_len=0 → no cyc assertion; done pulse 1 cycle after accept; cmd_ready low for that cycle.
